// File: rtl/pipelined_adder_n_bits.sv
// Pipelined NB_BITS add/subtract: one CHUNK-wide slice per stage, carry registered between stages,
// global valid/ready advance. Define ADDER_SAT_EN to add the sat_i port and signed saturation.
module pipelined_adder_n_bits #(
    parameter int NB_BITS   = 32,
    parameter int NB_STAGES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [NB_BITS-1:0] A_i,
    input  logic [NB_BITS-1:0] B_i,
    input  logic               Cin_i,
    input  logic               sub_i,
`ifdef ADDER_SAT_EN
    input  logic               sat_i,
`endif
    output logic               valid_o,
    input  logic               ready_i,
    output logic [NB_BITS-1:0] S_o,
    output logic               Cout_o,
    output logic               ovf_o,
    output logic               zero_o,
    output logic               neg_o
);

    localparam int CHUNK = NB_BITS / NB_STAGES;
    localparam int MSB   = NB_BITS - 1;
    localparam int LAST  = NB_STAGES - 1;
    localparam int NPIPE = (NB_STAGES > 1) ? NB_STAGES - 1 : 1;

    if ((NB_STAGES < 1) || (NB_STAGES > NB_BITS) || ((NB_BITS % NB_STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_adder_n_bits: NB_BITS (%0d) must be a multiple of NB_STAGES (%0d)",
               NB_BITS, NB_STAGES);
    end

    // Everything a stage needs: conditioned operands travel with the partial result.
    typedef struct packed {
        logic               v;
        logic [NB_BITS-1:0] a;
        logic [NB_BITS-1:0] b;
        logic [NB_BITS-1:0] s;
        logic               c;
        logic               sat;
    } stage_t;

    stage_t             pipe_q    [NPIPE];
    stage_t             stage_in  [NB_STAGES];
    stage_t             stage_out [NB_STAGES];
    logic [CHUNK:0]     chunk_sum [NB_STAGES];

    logic               adv;
    logic               sat_in;
    logic               a_msb;
    logic               b_msb;
    logic               ovf;
    logic [NB_BITS-1:0] raw_sum;
    logic [NB_BITS-1:0] final_sum;

`ifdef ADDER_SAT_EN
    assign sat_in = sat_i;
`else
    assign sat_in = 1'b0;
`endif

    assign adv     = ~valid_o | ready_i;
    assign ready_o = adv | rst_i;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        for (int k = 0; k < NB_STAGES; k++) begin
            stage_in[k] = '0;
        end
        stage_in[0].v   = valid_i;
        stage_in[0].a   = A_i;
        stage_in[0].b   = sub_i ? ~B_i : B_i;
        stage_in[0].c   = sub_i ^ Cin_i;
        stage_in[0].sat = sat_in;
        for (int k = 1; k < NB_STAGES; k++) begin
            stage_in[k] = pipe_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NB_STAGES; k++) begin
            chunk_sum[k] = {1'b0, stage_in[k].a[k*CHUNK +: CHUNK]}
                         + {1'b0, stage_in[k].b[k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, stage_in[k].c};
            stage_out[k]                     = stage_in[k];
            stage_out[k].s[k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
            stage_out[k].c                   = chunk_sum[k][CHUNK];
        end
    end

    // Flags come from the complete result, seen only in the last stage.
    always_comb begin
        raw_sum   = stage_out[LAST].s;
        a_msb     = stage_in[LAST].a[MSB];
        b_msb     = stage_in[LAST].b[MSB];
        ovf       = (a_msb == b_msb) && (raw_sum[MSB] != a_msb);
        final_sum = raw_sum;
        if (stage_in[LAST].sat && ovf) begin
            final_sum = a_msb ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the stage array is small and cleared explicitly so no stale operand can leak out.
            for (int k = 0; k < NPIPE; k++) begin
                pipe_q[k] <= '0;
            end
            valid_o <= 1'b0;
            S_o     <= '0;
            Cout_o  <= 1'b0;
            ovf_o   <= 1'b0;
            zero_o  <= 1'b0;
            neg_o   <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NB_STAGES - 1; k++) begin
                pipe_q[k] <= stage_out[k];
            end
            valid_o <= stage_in[LAST].v;
            S_o     <= final_sum;
            Cout_o  <= stage_out[LAST].c;
            ovf_o   <= ovf;
            zero_o  <= (final_sum == '0);
            neg_o   <= final_sum[MSB];
        end
    end

endmodule

// File: doc/pipelined_adder_n_bits.md
Name: pipelined_adder_n_bits

Overview:
Parametrised, pipelined successor to the combinational N-bit ripple adder.
- Splits the NB_BITS-wide add/subtract into NB_STAGES chunks, one chunk per clock stage.
- Registers the carry between stages.
- Adds valid/ready handshaking on input and output, plus add/sub mode and status flags.
- Sits in the datapath wherever a wide add must meet timing, e.g. multi-cycle ALU extensions or address/accumulator paths.

Parameters:
- NB_BITS, 32, operand and result width; must be a multiple of NB_STAGES.
- NB_STAGES, 4, number of pipeline stages; range 1..NB_BITS.
- CHUNK derived = NB_BITS/NB_STAGES, number of bits added per stage. Not overridable.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  input operation valid.
- ready_o  out  1  block can accept an operation this cycle.
- A_i  in  NB_BITS  operand A.
- B_i  in  NB_BITS  operand B.
- Cin_i  in  1  carry-in (add) / borrow-in (sub).
- sub_i  in  1  0 = add, 1 = subtract.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- S_o  out  NB_BITS  result.
- Cout_o  out  1  raw carry out of MSB.
- ovf_o  out  1  signed overflow.
- zero_o  out  1  S_o == 0.
- neg_o  out  1  S_o[NB_BITS-1].

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all stage valid bits = 0, valid_o = 0; S_o, Cout_o, ovf_o, zero_o, neg_o = 0. Data registers cleared.
- Operand conditioning at input: B' = sub_i ? ~B_i : B_i; c0 = sub_i ? ~Cin_i : Cin_i.
  - Add: S = A + B + Cin.
  - Sub: S = A - B - Cin_i.
  - Cout_o = 1 in sub means no borrow.
- Stage k (0..NB_STAGES-1):
  - Adds chunk k of A and B' with the carry registered by stage k-1 (c0 for k = 0).
  - Registers the sum chunk, the carry out and its valid bit.
  - Higher chunks of A and B', and lower result chunks, are carried forward in stage registers.
- Latency: a result appears on valid_o exactly NB_STAGES cycles after acceptance (valid_i & ready_o), absent stalls.
- Throughput: 1 op/cycle.
- Flow control is a global advance: adv = ~valid_o | ready_i.
  - ready_o = adv.
  - When adv = 1, all stages shift by one.
  - When adv = 0, all stages hold; S_o and flags remain stable while valid_o = 1.
  - Bubbles are not compressed.
- valid_i is sampled only when ready_o = 1. A valid_i dropped while ready_o = 0 is a protocol violation and its behaviour is unspecified.
- Flags are computed in the final stage from the full result:
  - ovf_o = (A[msb] == B'[msb]) & (S[msb] != A[msb]).
  - zero_o = (S == 0).
  - neg_o = S[msb].
- Ordering: results are delivered strictly in acceptance order. No loss or duplication under any ready_i pattern.
- Reset mid-operation: all in-flight operations are discarded. valid_o = 0 on the cycle after rst_i is sampled high. ready_o = 1 while rst_i is high and after it.
- NB_STAGES = 1: a single registered full-width add with latency 1.
- A width not divisible by NB_STAGES is illegal; elaboration fails via $error.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined:
  - Adds an input port sat_i (1 bit), captured with the operands.
  - When sat_i = 1 and ovf = 1, S_o is clamped: 0x7F..F if A[msb] = 0, else 0x80..0. ovf_o still reports 1.
  - zero_o and neg_o reflect the clamped value.
  - Cout_o stays the raw carry.
- Undefined: no sat_i port; S_o is always the wrapped result.

Test Plan:
- Reset: hold rst_i = 1 for 2 cycles with valid_i = 1 -> valid_o = 0, S_o = 0, all flags 0, ready_o = 1.
- Add wrap (NB_BITS = 32, NB_STAGES = 4): A = 0xFFFFFFFF, B = 0x00000001, Cin = 0, sub = 0 -> 4 cycles later S = 0x00000000, Cout = 1, zero = 1, ovf = 0. Exercises carry ripple through every stage.
- Subtract: A = 5, B = 7, Cin = 0, sub = 1 -> S = 0xFFFFFFFE, Cout = 0, neg = 1, ovf = 0. Also A = 7, B = 5, Cin = 1 -> S = 1, Cout = 1.
- Overflow: A = 0x7FFFFFFF, B = 1, add -> S = 0x80000000, ovf = 1, neg = 1. With ADDER_SAT_EN and sat_i = 1 -> S = 0x7FFFFFFF, ovf = 1, neg = 0.
- Backpressure: stream 8 back-to-back ops (A = i, B = 0x10 * i), with ready_i low for 3 cycles once valid_o is high -> ready_o low during the stall, S_o stable, all 8 results (0x11 * i) in order, no loss or duplication.
- Reset mid-stream: assert rst_i with 3 ops in flight -> next cycle valid_o = 0. The first op accepted after reset is returned correctly 4 cycles later with no stale data.
